mem_arbiter: RTL and testbench

Arbitrates the single byte-serial memory port between the instruction fetch unit and the load store buffer. Sits directly upstream of the memory controller: it latches one requester's transaction, presents it to the controller under the controller's hold-until-ready contract, and routes the one-cycle ready/data response back to the granted requester. LSB has priority, with a starvation guard that forces an instruction fetch grant after a bounded run of LSB grants.

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the byte-serial memory port to either the instruction
// fetch unit or the load/store buffer. The LSB is preferred, but after
// STARVE_LIMIT back-to-back LSB grants with a fetch waiting, the fetch is
// forced through. Every output comes straight from a register.

`ifndef LSB_TYPE_WIDTH
`define LSB_TYPE_WIDTH 4
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush,
    input  logic                       if_req,
    input  logic [31:0]                if_addr,
    output logic                       if_ack,
    output logic [31:0]                if_data,
    input  logic                       lsb_req,
    input  logic [31:0]                lsb_addr,
    input  logic [`LSB_TYPE_WIDTH-1:0] lsb_type,
    input  logic [31:0]                lsb_wdata,
    output logic                       lsb_ack,
    output logic [31:0]                lsb_rdata,
    output logic                       mem_en,
    output logic [31:0]                mem_addr,
    output logic [`LSB_TYPE_WIDTH-1:0] mem_type,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_rdy,
    input  logic [31:0]                mem_rdata
);

    localparam logic [2:0]                 LIMIT   = 3'(STARVE_LIMIT);
    localparam logic [`LSB_TYPE_WIDTH-1:0] IF_TYPE = `LSB_TYPE_WIDTH'(4'b0010);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_LSB = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [2:0]                 r_streak;
    logic [2:0]                 w_streak_next;

    logic                       r_mem_en,    w_mem_en_next;
    logic [31:0]                r_mem_addr,  w_mem_addr_next;
    logic [`LSB_TYPE_WIDTH-1:0] r_mem_type,  w_mem_type_next;
    logic [31:0]                r_mem_wdata, w_mem_wdata_next;
    logic                       r_if_ack,    w_if_ack_next;
    logic [31:0]                r_if_data,   w_if_data_next;
    logic                       r_lsb_ack,   w_lsb_ack_next;
    logic [31:0]                r_lsb_rdata, w_lsb_rdata_next;

    logic                       w_starved;
    logic                       w_lsb_grant;
    logic                       w_if_grant;

    // Fetch has waited through too many LSB grants: it must win this IDLE cycle.
    assign w_starved   = if_req && (r_streak >= LIMIT);
    assign w_lsb_grant = (r_state == S_IDLE) && lsb_req && !w_starved;
    assign w_if_grant  = (r_state == S_IDLE) && !w_lsb_grant && if_req;

    // State register: FSM state and starvation streak.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_streak <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    // Next-state logic; a flush always returns to IDLE with a fresh streak.
    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        if (rdy_in) begin
            if (flush) begin
                w_state_next  = S_IDLE;
                w_streak_next = 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_lsb_grant) begin
                            w_state_next  = S_BUSY_LSB;
                            w_streak_next = !if_req ? 3'd0 :
                                            (r_streak == 3'd7) ? 3'd7 : r_streak + 3'd1;
                        end else if (w_if_grant) begin
                            w_state_next  = S_BUSY_IF;
                            w_streak_next = 3'd0;
                        end else begin
                            w_streak_next = 3'd0;
                        end
                    end
                    S_BUSY_IF, S_BUSY_LSB: begin
                        if (mem_rdy) w_state_next = S_RELEASE;
                    end
                    S_RELEASE: w_state_next = S_IDLE;
                    default:   w_state_next = S_IDLE;
                endcase
            end
        end
    end

    // Output logic: next values for the registered memory request and responses.
    always_comb begin
        w_mem_en_next    = r_mem_en;
        w_mem_addr_next  = r_mem_addr;
        w_mem_type_next  = r_mem_type;
        w_mem_wdata_next = r_mem_wdata;
        w_if_ack_next    = r_if_ack;
        w_if_data_next   = r_if_data;
        w_lsb_ack_next   = r_lsb_ack;
        w_lsb_rdata_next = r_lsb_rdata;
        if (rdy_in) begin
            if (flush) begin
                w_mem_en_next  = 1'b0;
                w_if_ack_next  = 1'b0;
                w_lsb_ack_next = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_lsb_grant) begin
                            w_mem_en_next    = 1'b1;
                            w_mem_addr_next  = lsb_addr;
                            w_mem_type_next  = lsb_type;
                            w_mem_wdata_next = lsb_wdata;
                        end else if (w_if_grant) begin
                            w_mem_en_next    = 1'b1;
                            w_mem_addr_next  = if_addr;
                            w_mem_type_next  = IF_TYPE;
                            w_mem_wdata_next = 32'd0;
                        end
                    end
                    S_BUSY_IF: begin
                        if (mem_rdy) begin
                            w_mem_en_next  = 1'b0;
                            w_if_ack_next  = 1'b1;
                            w_if_data_next = mem_rdata;
                        end
                    end
                    S_BUSY_LSB: begin
                        if (mem_rdy) begin
                            w_mem_en_next    = 1'b0;
                            w_lsb_ack_next   = 1'b1;
                            w_lsb_rdata_next = mem_rdata;
                        end
                    end
                    S_RELEASE: begin
                        w_if_ack_next  = 1'b0;
                        w_lsb_ack_next = 1'b0;
                    end
                    default: begin
                        w_mem_en_next  = 1'b0;
                        w_if_ack_next  = 1'b0;
                        w_lsb_ack_next = 1'b0;
                    end
                endcase
            end
        end
    end

    // Output registers; reset clears them immediately, independent of the clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_en    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_type  <= '0;
            r_mem_wdata <= 32'd0;
            r_if_ack    <= 1'b0;
            r_if_data   <= 32'd0;
            r_lsb_ack   <= 1'b0;
            r_lsb_rdata <= 32'd0;
        end else begin
            r_mem_en    <= w_mem_en_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_type  <= w_mem_type_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_if_ack    <= w_if_ack_next;
            r_if_data   <= w_if_data_next;
            r_lsb_ack   <= w_lsb_ack_next;
            r_lsb_rdata <= w_lsb_rdata_next;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign mem_type  = r_mem_type;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign if_data   = r_if_data;
    assign lsb_ack   = r_lsb_ack;
    assign lsb_rdata = r_lsb_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a vector table for the basic transactions,
// hand-written sequences for starvation, flush, stall and async reset, then
// randomized traffic compared against a transaction-level reference model.

`ifndef LSB_TYPE_WIDTH
`define LSB_TYPE_WIDTH 4
`endif

module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        if_req, lsb_req, mem_rdy;
    logic [31:0] if_addr, lsb_addr, lsb_wdata, mem_rdata;
    logic [3:0]  lsb_type;
    logic        if_ack, lsb_ack, mem_en;
    logic [31:0] if_data, lsb_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_type;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_type(lsb_type),
        .lsb_wdata(lsb_wdata), .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_type(mem_type),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ifr;  logic [31:0] ifa;
        logic        lr;   logic [31:0] la; logic [3:0] lt; logic [31:0] lw;
        logic        mr;   logic [31:0] md;
        logic        e_en; logic [31:0] e_addr; logic [3:0] e_type; logic [31:0] e_wd;
        logic        e_ia; logic [31:0] e_id;
        logic        e_la; logic [31:0] e_ld;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa,
        input logic lr, input logic [31:0] la, input logic [3:0] lt, input logic [31:0] lw,
        input logic mr, input logic [31:0] md,
        input logic e_en, input logic [31:0] e_addr, input logic [3:0] e_type,
        input logic [31:0] e_wd, input logic e_ia, input logic [31:0] e_id,
        input logic e_la, input logic [31:0] e_ld);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.lr = lr; v.la = la; v.lt = lt; v.lw = lw;
        v.mr = mr; v.md = md; v.e_en = e_en; v.e_addr = e_addr; v.e_type = e_type;
        v.e_wd = e_wd; v.e_ia = e_ia; v.e_id = e_id; v.e_la = e_la; v.e_ld = e_ld;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (mem_en) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // Reference model: who owns the port, whether the post-ack quiet cycle is
    // pending, and how many LSB grants the current fetch has sat through.
    int          m_owner;   // 0 none, 1 ifetch, 2 LSB
    bit          m_quiet;
    int          m_streak;
    logic        m_en, m_ia, m_la;
    logic [31:0] m_addr, m_wd, m_id, m_ld;
    logic [3:0]  m_type;

    task automatic model_step();
        if (!rdy_in) return;
        if (flush) begin
            m_owner = 0; m_quiet = 0; m_streak = 0; m_en = 0; m_ia = 0; m_la = 0;
            return;
        end
        m_ia = 0; m_la = 0;
        if (m_owner != 0) begin
            if (mem_rdy) begin
                if (m_owner == 1) begin m_ia = 1; m_id = mem_rdata; end
                else begin m_la = 1; m_ld = mem_rdata; end
                m_en = 0; m_owner = 0; m_quiet = 1;
            end
        end else if (m_quiet) begin
            m_quiet = 0;
        end else if (lsb_req && !(if_req && m_streak >= STARVE)) begin
            m_owner = 2; m_en = 1; m_addr = lsb_addr; m_type = lsb_type; m_wd = lsb_wdata;
            m_streak = !if_req ? 0 : (m_streak >= 7 ? 7 : m_streak + 1);
        end else if (if_req) begin
            m_owner = 1; m_en = 1; m_addr = if_addr; m_type = 4'b0010; m_wd = 0;
            m_streak = 0;
        end else begin
            m_streak = 0;
        end
    endtask

    initial begin
        bit ok;
        bit adv;
        int ack_cnt;
        int n_txn;

        rst_in = 1; rdy_in = 1; flush = 0; if_req = 0; if_addr = 0;
        lsb_req = 0; lsb_addr = 0; lsb_type = 0; lsb_wdata = 0;
        mem_rdy = 0; mem_rdata = 0;

        // ---------------- reset state ----------------
        @(negedge clk_in);
        cyc();
        rst_in = 0;
        chk("reset.mem_en", 32'(mem_en), 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_type", 32'(mem_type), 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.if_ack", 32'(if_ack), 0);
        chk("reset.lsb_ack", 32'(lsb_ack), 0);
        chk("reset.if_data", if_data, 0);
        chk("reset.lsb_rdata", lsb_rdata, 0);
        $display("reset: outputs sampled after reset");

        // ---------------- vector table ----------------
        // lone ifetch 0x1000, mem_rdy after five cycles with mem_en high
        for (int i = 0; i < 5; i++)
            vt[i] = mk(1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                       1'b1, 32'h1000, 4'h2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        vt[5]  = mk(1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h00C00093,
                    1'b0, 32'h1000, 4'h2, 32'h0, 1'b1, 32'h00C00093, 1'b0, 32'h0);
        vt[6]  = mk(1'b0, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h1000, 4'h2, 32'h0, 1'b0, 32'h00C00093, 1'b0, 32'h0);
        vt[7]  = vt[6];
        // simultaneous requests: LSB first, then the waiting fetch
        vt[8]  = mk(1'b1, 32'h2000, 1'b1, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b1, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h00C00093, 1'b0, 32'h0);
        vt[9]  = mk(1'b1, 32'h2000, 1'b1, 32'h20, 4'hA, 32'hDEADBEEF, 1'b1, 32'h11223344,
                    1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h00C00093, 1'b1, 32'h11223344);
        vt[10] = mk(1'b1, 32'h2000, 1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h00C00093, 1'b0, 32'h11223344);
        vt[11] = mk(1'b1, 32'h2000, 1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b1, 32'h2000, 4'h2, 32'h0, 1'b0, 32'h00C00093, 1'b0, 32'h11223344);
        vt[12] = mk(1'b1, 32'h2000, 1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D,
                    1'b0, 32'h2000, 4'h2, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h11223344);
        vt[13] = mk(1'b0, 32'h2000, 1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b0, 32'h2000, 4'h2, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h11223344);
        // stray mem_rdy while idle is ignored
        vt[14] = mk(1'b0, 32'h2000, 1'b0, 32'h20, 4'hA, 32'hDEADBEEF, 1'b1, 32'h55555555,
                    1'b0, 32'h2000, 4'h2, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h11223344);

        for (int i = 0; i < 15; i++) begin
            if_req = vt[i].ifr; if_addr = vt[i].ifa;
            lsb_req = vt[i].lr; lsb_addr = vt[i].la; lsb_type = vt[i].lt; lsb_wdata = vt[i].lw;
            mem_rdy = vt[i].mr; mem_rdata = vt[i].md;
            cyc();
            chk($sformatf("vec%0d.mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d.mem_type", i), 32'(mem_type), 32'(vt[i].e_type));
            chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, vt[i].e_wd);
            chk($sformatf("vec%0d.if_ack", i), 32'(if_ack), 32'(vt[i].e_ia));
            chk($sformatf("vec%0d.if_data", i), if_data, vt[i].e_id);
            chk($sformatf("vec%0d.lsb_ack", i), 32'(lsb_ack), 32'(vt[i].e_la));
            chk($sformatf("vec%0d.lsb_rdata", i), lsb_rdata, vt[i].e_ld);
            $display("vec%0d: mem_en=%b addr=%h if_ack=%b lsb_ack=%b", i, mem_en, mem_addr, if_ack, lsb_ack);
        end
        mem_rdy = 0;

        // ---------------- starvation: 4 LSB grants, fetch, LSB again ----------------
        if_req = 1; if_addr = 32'h3000;
        lsb_req = 1; lsb_addr = 32'h40; lsb_type = 4'h2; lsb_wdata = 32'h0;
        for (int g = 0; g < 6; g++) begin
            wait_en(ok);
            chk($sformatf("starve%0d.grant_seen", g), 32'(ok), 1);
            chk($sformatf("starve%0d.mem_addr", g), mem_addr, (g == 4) ? 32'h3000 : 32'h40);
            mem_rdy = 1; mem_rdata = 32'(g);
            cyc();
            mem_rdy = 0;
            chk($sformatf("starve%0d.if_ack", g), 32'(if_ack), (g == 4) ? 1 : 0);
            chk($sformatf("starve%0d.lsb_ack", g), 32'(lsb_ack), (g == 4) ? 0 : 1);
            $display("starve grant %0d: addr=%h if_ack=%b lsb_ack=%b", g, mem_addr, if_ack, lsb_ack);
        end
        if_req = 0; lsb_req = 0;
        cyc(); cyc(); cyc();

        // ---------------- flush during BUSY_IF with mem_rdy ----------------
        if_req = 1; if_addr = 32'h5000;
        cyc();
        chk("flush.granted", 32'(mem_en), 1);
        cyc();
        flush = 1; mem_rdy = 1; mem_rdata = 32'hBAD0BAD0;
        cyc();
        chk("flush.if_ack", 32'(if_ack), 0);
        chk("flush.mem_en", 32'(mem_en), 0);
        chk("flush.if_data_held", if_data, 32'h4);
        flush = 0; mem_rdy = 0; if_req = 0;
        lsb_req = 1; lsb_addr = 32'h70; lsb_type = 4'h1; lsb_wdata = 32'h99;
        cyc();
        chk("flush.idle_grant_en", 32'(mem_en), 1);
        chk("flush.idle_grant_addr", mem_addr, 32'h70);
        chk("flush.no_late_ack", 32'(if_ack), 0);
        $display("flush: mem_en=%b addr=%h if_ack=%b", mem_en, mem_addr, if_ack);
        mem_rdy = 1; mem_rdata = 32'h77777777;
        cyc();
        chk("flush.lsb_ack", 32'(lsb_ack), 1);
        lsb_req = 0; mem_rdy = 0;
        cyc(); cyc();

        // ---------------- rdy_in stall in BUSY_LSB ----------------
        lsb_req = 1; lsb_addr = 32'h60; lsb_type = 4'h5; lsb_wdata = 32'h12345678;
        cyc();
        chk("stall.granted", 32'(mem_en), 1);
        mem_rdy = 1; mem_rdata = 32'hA5A5A5A5; rdy_in = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("stall%0d.mem_en", k), 32'(mem_en), 1);
            chk($sformatf("stall%0d.lsb_ack", k), 32'(lsb_ack), 0);
            chk($sformatf("stall%0d.lsb_rdata", k), lsb_rdata, 32'h77777777);
        end
        rdy_in = 1;
        cyc();
        chk("stall.lsb_ack", 32'(lsb_ack), 1);
        chk("stall.lsb_rdata", lsb_rdata, 32'hA5A5A5A5);
        chk("stall.mem_en_low", 32'(mem_en), 0);
        $display("stall: lsb_ack=%b rdata=%h", lsb_ack, lsb_rdata);
        mem_rdy = 0; lsb_req = 0;
        ack_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (lsb_ack) ack_cnt++;
        end
        chk("stall.single_ack", 32'(ack_cnt), 0);

        // ---------------- asynchronous reset in BUSY_LSB ----------------
        lsb_req = 1; lsb_addr = 32'h80; lsb_type = 4'h2; lsb_wdata = 32'h0;
        cyc();
        chk("areset.granted", 32'(mem_en), 1);
        #2 rst_in = 1;
        #1;
        chk("areset.mem_en", 32'(mem_en), 0);
        chk("areset.mem_addr", mem_addr, 0);
        chk("areset.acks", 32'({if_ack, lsb_ack}), 0);
        chk("areset.data", if_data | lsb_rdata, 0);
        $display("async reset: mem_en=%b addr=%h", mem_en, mem_addr);
        lsb_req = 0;
        @(negedge clk_in);
        rst_in = 0;
        if_req = 1; if_addr = 32'h90;
        cyc();
        chk("areset.fresh_en", 32'(mem_en), 1);
        chk("areset.fresh_addr", mem_addr, 32'h90);
        chk("areset.fresh_type", 32'(mem_type), 32'h2);
        mem_rdy = 1; mem_rdata = 32'h0BADF00D;
        cyc();
        chk("areset.fresh_ack", 32'(if_ack), 1);
        if_req = 0; mem_rdy = 0;
        cyc();

        // ---------------- randomized traffic against the model ----------------
        rst_in = 1;
        cyc();
        rst_in = 0;
        m_owner = 0; m_quiet = 0; m_streak = 0;
        m_en = 0; m_addr = 0; m_type = 0; m_wd = 0; m_ia = 0; m_id = 0; m_la = 0; m_ld = 0;
        adv = 1; n_txn = 0;
        for (int c = 0; c < 3000; c++) begin
            chk($sformatf("rand%0d.mem_en", c), 32'(mem_en), 32'(m_en));
            chk($sformatf("rand%0d.mem_addr", c), mem_addr, m_addr);
            chk($sformatf("rand%0d.mem_type", c), 32'(mem_type), 32'(m_type));
            chk($sformatf("rand%0d.mem_wdata", c), mem_wdata, m_wd);
            chk($sformatf("rand%0d.if_ack", c), 32'(if_ack), 32'(m_ia));
            chk($sformatf("rand%0d.if_data", c), if_data, m_id);
            chk($sformatf("rand%0d.lsb_ack", c), 32'(lsb_ack), 32'(m_la));
            chk($sformatf("rand%0d.lsb_rdata", c), lsb_rdata, m_ld);
            if (adv && (if_ack || lsb_ack)) begin
                n_txn++;
                $display("rand txn %0d: %s data=%h", n_txn, if_ack ? "IF " : "LSB",
                         if_ack ? if_data : lsb_rdata);
            end
            if (adv) begin
                if (if_ack) if_req = 0;
                if (!if_req && $urandom_range(2) == 0) begin
                    if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (lsb_ack) lsb_req = 0;
                if (!lsb_req && $urandom_range(2) == 0) begin
                    lsb_req = 1; lsb_addr = $urandom;
                    lsb_type = 4'($urandom_range(15)); lsb_wdata = $urandom;
                end
                mem_rdy = mem_en ? ($urandom_range(3) == 0) : ($urandom_range(9) == 0);
                mem_rdata = $urandom;
            end
            flush  = ($urandom_range(39) == 0);
            rdy_in = ($urandom_range(7) != 0);
            model_step();
            adv = rdy_in;
            cyc();
        end
        chk("rand.progress", 32'(n_txn > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
